// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the 640x480 VGA path.
// Divides clk into a pixel enable, runs the horizontal/vertical counters and
// emits registered sync, visible-window and line/frame strobe outputs.
// Every output is decoded from the next-state counter values, so it lines up
// with the hCount/vCount visible in the same cycle and is glitch-free.
module vga_timing_gen #(
   parameter int CLK_DIV     = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_ACT_START = 144,
   parameter int H_ACT_END   = 783,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_ACT_START = 35,
   parameter int V_ACT_END   = 514
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       pixEn,
   output logic       lineStart,
   output logic       frameStart
);

   // Parameter legality, rejected at elaboration.
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : gBadDiv
      $error("vga_timing_gen: CLK_DIV must be 1..16");
   end
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gBadTotal
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
   end
   if (H_ACT_END >= H_TOTAL || V_ACT_END >= V_TOTAL) begin : gBadActive
      $error("vga_timing_gen: ACT_END must be below TOTAL");
   end

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
   localparam logic [9:0] H_ACT_S  = 10'(H_ACT_START);
   localparam logic [9:0] H_ACT_E  = 10'(H_ACT_END);
   localparam logic [9:0] V_ACT_S  = 10'(V_ACT_START);
   localparam logic [9:0] V_ACT_E  = 10'(V_ACT_END);

   logic [3:0] div;
   logic [3:0] divNext;
   logic [9:0] hNext;
   logic [9:0] vNext;
   logic       tick;
   logic       hWrap;
   logic       vWrap;
   logic       pixEnNext;

   // The counters advance on the last clk of each pixel period. This is the
   // combinational form of pixEn, so with CLK_DIV=1 the counters move from the
   // very first clk after reset even though the registered pixEn still holds
   // its reset value in that clk.
   assign tick  = (div == DIV_LAST);
   assign hWrap = tick && (hCount == H_LAST);
   assign vWrap = hWrap && (vCount == V_LAST);

   // Next-state values for the divider and both raster counters.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      divNext   = tick ? 4'd0 : div + 4'd1;
      hNext     = hCount;
      vNext     = vCount;
      pixEnNext = (divNext == DIV_LAST);
      if (tick) begin
         hNext = hWrap ? 10'd0 : hCount + 10'd1;
         if (hWrap) begin
            vNext = vWrap ? 10'd0 : vCount + 10'd1;
         end
      end
   end

   // State and output registers; reset wins over any wrap in the same clk.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         div        <= 4'd0;
         hCount     <= 10'd0;
         vCount     <= 10'd0;
         hSync      <= 1'b0;
         vSync      <= 1'b0;
         bright     <= 1'b0;
         pixEn      <= 1'b0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         div        <= divNext;
         hCount     <= hNext;
         vCount     <= vNext;
         hSync      <= (hNext >= H_SYNC_W);
         vSync      <= (vNext >= V_SYNC_W);
         bright     <= (hNext >= H_ACT_S) && (hNext <= H_ACT_E) &&
                       (vNext >= V_ACT_S) && (vNext <= V_ACT_E);
         pixEn      <= pixEnNext;
         lineStart  <= hWrap;
         frameStart <= vWrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances (default geometry, a shrunken raster at
// CLK_DIV=4, and the same raster at CLK_DIV=1) checked every cycle against an
// arithmetic model of the raster, plus directed literal expectations.
module tb_vga_timing_gen;

   typedef logic [25:0] vec_t;

   // Shrunken raster so whole frames fit in a short run.
   localparam int BH = 20, BHS = 3, BHA = 5, BHE = 16;
   localparam int BV = 12, BVS = 2, BVA = 3, BVE = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstA, rstB, rstC;
   logic hSyncA, vSyncA, brightA, pixEnA, lineStartA, frameStartA;
   logic hSyncB, vSyncB, brightB, pixEnB, lineStartB, frameStartB;
   logic hSyncC, vSyncC, brightC, pixEnC, lineStartC, frameStartC;
   logic [9:0] hCountA, vCountA, hCountB, vCountB, hCountC, vCountC;

   vga_timing_gen dutA (
      .clk(clk), .reset(rstA), .hSync(hSyncA), .vSync(vSyncA), .bright(brightA),
      .hCount(hCountA), .vCount(vCountA), .pixEn(pixEnA),
      .lineStart(lineStartA), .frameStart(frameStartA));

   vga_timing_gen #(
      .CLK_DIV(4), .H_TOTAL(BH), .H_SYNC(BHS), .H_ACT_START(BHA), .H_ACT_END(BHE),
      .V_TOTAL(BV), .V_SYNC(BVS), .V_ACT_START(BVA), .V_ACT_END(BVE)
   ) dutB (
      .clk(clk), .reset(rstB), .hSync(hSyncB), .vSync(vSyncB), .bright(brightB),
      .hCount(hCountB), .vCount(vCountB), .pixEn(pixEnB),
      .lineStart(lineStartB), .frameStart(frameStartB));

   vga_timing_gen #(
      .CLK_DIV(1), .H_TOTAL(BH), .H_SYNC(BHS), .H_ACT_START(BHA), .H_ACT_END(BHE),
      .V_TOTAL(BV), .V_SYNC(BVS), .V_ACT_START(BVA), .V_ACT_END(BVE)
   ) dutC (
      .clk(clk), .reset(rstC), .hSync(hSyncC), .vSync(vSyncC), .bright(brightC),
      .hCount(hCountC), .vCount(vCountC), .pixEn(pixEnC),
      .lineStart(lineStartC), .frameStart(frameStartC));

   vec_t actA, actB, actC;
   assign actA = {hSyncA, vSyncA, brightA, pixEnA, lineStartA, frameStartA, hCountA, vCountA};
   assign actB = {hSyncB, vSyncB, brightB, pixEnB, lineStartB, frameStartB, hCountB, vCountB};
   assign actC = {hSyncC, vSyncC, brightC, pixEnC, lineStartC, frameStartC, hCountC, vCountC};

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // Outputs as a pure function of t = clks since the last reset edge
   // (t=0 is the first clk with reset released, showing reset values).
   function automatic vec_t model(input int t, input int d, input int ht, input int hs,
                                  input int has, input int hae, input int vt, input int vs,
                                  input int vas, input int vae);
      int pix, h, v;
      logic pe, ls, fs, hsy, vsy, br;
      pix = t / d;
      h   = pix % ht;
      v   = (pix / ht) % vt;
      pe  = (t > 0) && (t % d == d - 1);
      ls  = (t > 0) && (t % (ht * d) == 0);
      fs  = (t > 0) && (t % (ht * vt * d) == 0);
      hsy = !(h < hs);
      vsy = !(v < vs);
      br  = (h >= has) && (h <= hae) && (v >= vas) && (v <= vae);
      return {hsy, vsy, br, pe, ls, fs, 10'(h), 10'(v)};
   endfunction

   int tA = 0, tB = 0, tC = 0;
   logic armed = 1'b0;
   logic phase1 = 1'b1;

   // Time since each instance's most recent reset edge.
   always @(posedge clk) begin
      tA <= rstA ? tA + 1 : 0;
      tB <= rstB ? tB + 1 : 0;
      tC <= rstC ? tC + 1 : 0;
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (armed) begin
         check("modelA", 32'(actA), 32'(model(tA, 4, 800, 96, 144, 783, 525, 2, 35, 514)));
         check("modelB", 32'(actB), 32'(model(tB, 4, BH, BHS, BHA, BHE, BV, BVS, BVA, BVE)));
         check("modelC", 32'(actC), 32'(model(tC, 1, BH, BHS, BHA, BHE, BV, BVS, BVA, BVE)));
      end
   end

   // Directed measurements collected during the first free-running stretch.
   int firstPixA = -1, firstH1A = -1, firstLineA = -1, hLowA = 0, riseHA = -1, risePrevA = -1;
   logic prevHSyncA = 1'b0;
   int prevHCA = 0;
   int fsTimeB[3];
   int fsCntB = 0, lsCntB = 0, vLowB = 0, riseB = -1, fallB = -1, badB = 0;
   logic prevBrightB = 1'b0;
   int fsTimeC[2];
   int fsCntC = 0, pixLowC = 0, stepErrC = 0, prevHCC = 0;

   always @(negedge clk) begin
      if (phase1 && tA > 0) begin
         if (pixEnA && firstPixA < 0) firstPixA = tA;
         if (hCountA == 10'd1 && firstH1A < 0) firstH1A = tA;
         if (lineStartA && firstLineA < 0) firstLineA = tA;
         // Window [1,3200] spans exactly one line period.
         if (tA <= 3200 && !hSyncA) hLowA++;
         if (hSyncA && !prevHSyncA && riseHA < 0) begin
            riseHA    = int'(hCountA);
            risePrevA = prevHCA;
         end
      end
      prevHSyncA = hSyncA;
      prevHCA    = int'(hCountA);

      if (phase1 && tB > 0) begin
         if (frameStartB) begin
            if (fsCntB < 3) fsTimeB[fsCntB] = tB;
            fsCntB++;
         end
         if (lineStartB && fsCntB == 1) lsCntB++;
         if (!vSyncB && fsCntB == 1) vLowB++;
         if (brightB && !prevBrightB && vCountB == 10'd3 && riseB < 0) riseB = int'(hCountB);
         if (!brightB && prevBrightB && vCountB == 10'd3 && fallB < 0) fallB = int'(hCountB);
         if (brightB && (vCountB == 10'd2 || vCountB == 10'd10)) badB++;
      end
      prevBrightB = brightB;

      if (phase1 && tC > 0) begin
         if (frameStartC) begin
            if (fsCntC < 2) fsTimeC[fsCntC] = tC;
            fsCntC++;
         end
         if (!pixEnC) pixLowC++;
         if (int'(hCountC) != (prevHCC + 1) % BH) stepErrC++;
      end
      prevHCC = int'(hCountC);
   end

   initial begin
      int n;
      rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;

      // Hold reset for 5 clks; every output must sit at its reset value.
      repeat (5) begin
         @(negedge clk);
         armed = 1'b1;
         check("resetHoldA", 32'(actA), 32'd0);
         check("resetHoldB", 32'(actB), 32'd0);
      end
      rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;

      repeat (3305) @(negedge clk);
      phase1 = 1'b0;

      check("pixEnFirstCycle", 32'(firstPixA), 32'd3);
      check("hCount1FirstCycle", 32'(firstH1A), 32'd4);
      check("lineStartFirstCycle", 32'(firstLineA), 32'd3200);
      check("hSyncLowClks", 32'(hLowA), 32'd384);
      check("hSyncRiseAtH", 32'(riseHA), 32'd96);
      check("hSyncRisePrevH", 32'(risePrevA), 32'd95);
      check("frameCountB", 32'(fsCntB), 32'd3);
      check("firstFrameB", 32'(fsTimeB[0]), 32'd960);
      check("framePeriodB1", 32'(fsTimeB[1] - fsTimeB[0]), 32'd960);
      check("framePeriodB2", 32'(fsTimeB[2] - fsTimeB[1]), 32'd960);
      check("lineStartsPerFrameB", 32'(lsCntB), 32'd12);
      check("vSyncLowClksB", 32'(vLowB), 32'd160);
      check("brightRiseH", 32'(riseB), 32'd5);
      check("brightFallH", 32'(fallB), 32'd17);
      check("brightOutsideV", 32'(badB), 32'd0);
      check("firstFrameC", 32'(fsTimeC[0]), 32'd240);
      check("framePeriodC", 32'(fsTimeC[1] - fsTimeC[0]), 32'd240);
      check("pixEnLowC", 32'(pixLowC), 32'd0);
      check("hStepErrC", 32'(stepErrC), 32'd0);

      // Mid-frame reset for one clk at hCount=10, vCount=6.
      n = 0;
      while (!(hCountB == 10'd10 && vCountB == 10'd6) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reachMidFrame", 32'(hCountB == 10'd10 && vCountB == 10'd6), 32'd1);
      rstB = 1'b0;
      @(negedge clk);
      rstB = 1'b1;
      check("midResetCounters", 32'({hCountB, vCountB}), 32'd0);
      check("midResetStrobes", 32'({lineStartB, frameStartB}), 32'd0);
      n = 0;
      while (!frameStartB && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("frameAfterMidReset", 32'(n), 32'd960);

      // Reset landing on the frame wrap edge suppresses both strobes.
      n = 0;
      while (!(hCountB == 10'd19 && vCountB == 10'd11 && pixEnB) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reachFrameWrap", 32'(hCountB == 10'd19 && vCountB == 10'd11 && pixEnB), 32'd1);
      rstB = 1'b0;
      @(negedge clk);
      rstB = 1'b1;
      check("wrapResetStrobes", 32'({lineStartB, frameStartB}), 32'd0);
      check("wrapResetCounters", 32'({hCountB, vCountB}), 32'd0);

      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
